// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder
//   AXI4 slave RAM serving a single 32-bit master, one burst in flight at a
//   time. It handles FIXED/INCR/WRAP bursts of up to 256 beats at one beat
//   per cycle, with byte-strobe writes. Beats outside the RAM window are
//   answered with DECERR: writes to them are dropped and reads return zero.
//
//   State table
//     state | meaning
//     IDLE  | waiting for AW or AR; the only state where the readies follow the valids
//     WDATA | accepting W beats of the latched write burst
//     WRESP | presenting B until bready
//     RDATA | presenting R beats of the latched read burst
//
//   Ports
//     clk_i, rst_i              clock, async active-high reset
//     axi_aw*                   write address channel (addr, id, len, burst)
//     axi_w*                    write data channel (data, strb, last)
//     axi_b*                    write response channel (resp, id)
//     axi_ar*                   read address channel (addr, id, len, burst)
//     axi_r*                    read data channel (data, resp, id, last)
module axi4_mem_responder #(
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter int          MEM_WORDS_W = 14
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o
);

  localparam int DEPTH = 1 << MEM_WORDS_W;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [3:0]  id;
  logic [7:0]  len;
  logic [7:0]  beat_cnt;
  logic [1:0]  burst;
  logic        err;
  logic        prio_wr;

  logic [31:0] mem [DEPTH];

  logic [31:0] nxt_addr;
  logic [31:0] wrap_mask;
  logic [31:0] rd_addr;
  logic [31:0] rd_off;
  logic [31:0] wr_off;
  logic        rd_oor;
  logic        wr_oor;
  logic [MEM_WORDS_W-1:0] rd_idx;
  logic [MEM_WORDS_W-1:0] wr_idx;
  logic        aw_hs;
  logic        ar_hs;
  logic        last_beat;

  // wlast carries no information here: the burst length comes from awlen.
  logic unused_ok;
  assign unused_ok = ^{axi_wlast_i, rd_off[1:0], wr_off[1:0]};

  assign axi_awready_o = !rst_i && (state == IDLE) && axi_awvalid_i &&
                         (!axi_arvalid_i || prio_wr);
  assign axi_arready_o = !rst_i && (state == IDLE) && axi_arvalid_i &&
                         (!axi_awvalid_i || !prio_wr);
  assign axi_wready_o  = (state == WDATA);

  assign aw_hs     = axi_awvalid_i && axi_awready_o;
  assign ar_hs     = axi_arvalid_i && axi_arready_o;
  assign last_beat = (beat_cnt == len);

  // WRAP with len+1 a power of two: the block size minus one is len*4+3.
  // Any other len under WRAP behaves like INCR.
  always_comb begin
    wrap_mask = 32'h0;
    nxt_addr  = addr + 32'd4;
    if (burst == 2'b00) begin
      nxt_addr = addr;
    end else if (burst == 2'b10 &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      wrap_mask = {22'b0, len, 2'b11};
      nxt_addr  = (addr & ~wrap_mask) | ((addr + 32'd4) & wrap_mask);
    end
  end

  // Read-side address: beat 0 comes straight from AR, later beats from the advance.
  assign rd_addr = (state == IDLE) ? (axi_araddr_i & ~32'h3) : nxt_addr;
  assign rd_off  = rd_addr - MEM_BASE;
  assign rd_oor  = (rd_off >> (MEM_WORDS_W + 2)) != 32'd0;
  assign rd_idx  = rd_off[MEM_WORDS_W+1:2];

  assign wr_off  = addr - MEM_BASE;
  assign wr_oor  = (wr_off >> (MEM_WORDS_W + 2)) != 32'd0;
  assign wr_idx  = wr_off[MEM_WORDS_W+1:2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      addr         <= 32'h0;
      id           <= 4'h0;
      len          <= 8'h0;
      beat_cnt     <= 8'h0;
      burst        <= 2'b00;
      err          <= 1'b0;
      prio_wr      <= 1'b0;
      axi_bvalid_o <= 1'b0;
      axi_bresp_o  <= 2'b00;
      axi_bid_o    <= 4'h0;
      axi_rvalid_o <= 1'b0;
      axi_rdata_o  <= 32'h0;
      axi_rresp_o  <= 2'b00;
      axi_rid_o    <= 4'h0;
      axi_rlast_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            addr     <= axi_awaddr_i & ~32'h3;
            id       <= axi_awid_i;
            len      <= axi_awlen_i;
            burst    <= axi_awburst_i;
            beat_cnt <= 8'h0;
            err      <= 1'b0;
            if (axi_arvalid_i) prio_wr <= ~prio_wr;
            state    <= WDATA;
          end else if (ar_hs) begin
            addr         <= axi_araddr_i & ~32'h3;
            id           <= axi_arid_i;
            len          <= axi_arlen_i;
            burst        <= axi_arburst_i;
            beat_cnt     <= 8'h0;
            err          <= 1'b0;
            if (axi_awvalid_i) prio_wr <= ~prio_wr;
            axi_rvalid_o <= 1'b1;
            axi_rdata_o  <= rd_oor ? 32'h0 : mem[rd_idx];
            axi_rresp_o  <= rd_oor ? 2'b11 : 2'b00;
            axi_rid_o    <= axi_arid_i;
            axi_rlast_o  <= (axi_arlen_i == 8'h0);
            state        <= RDATA;
          end
        end
        WDATA: begin
          if (axi_wvalid_i) begin
            if (wr_oor) err <= 1'b1;
            if (last_beat) begin
              axi_bvalid_o <= 1'b1;
              axi_bid_o    <= id;
              axi_bresp_o  <= (err || wr_oor) ? 2'b11 : 2'b00;
              state        <= WRESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              addr     <= nxt_addr;
            end
          end
        end
        WRESP: begin
          if (axi_bready_i) begin
            axi_bvalid_o <= 1'b0;
            axi_bresp_o  <= 2'b00;
            axi_bid_o    <= 4'h0;
            state        <= IDLE;
          end
        end
        RDATA: begin
          if (axi_rready_i) begin
            if (last_beat) begin
              axi_rvalid_o <= 1'b0;
              axi_rdata_o  <= 32'h0;
              axi_rresp_o  <= 2'b00;
              axi_rid_o    <= 4'h0;
              axi_rlast_o  <= 1'b0;
              state        <= IDLE;
            end else begin
              beat_cnt    <= beat_cnt + 8'd1;
              addr        <= nxt_addr;
              axi_rdata_o <= rd_oor ? 32'h0 : mem[rd_idx];
              axi_rresp_o <= rd_oor ? 2'b11 : 2'b00;
              axi_rlast_o <= ((beat_cnt + 8'd1) == len);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; writes only happen in WDATA, which reset leaves.
  always_ff @(posedge clk_i) begin
    if (state == WDATA && axi_wvalid_i && !wr_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (axi_wstrb_i[i]) mem[wr_idx][8*i +: 8] <= axi_wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
module tb_axi4_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        axi_awvalid_i = 1'b0;
  logic        axi_awready_o;
  logic [31:0] axi_awaddr_i = 32'h0;
  logic [3:0]  axi_awid_i = 4'h0;
  logic [7:0]  axi_awlen_i = 8'h0;
  logic [1:0]  axi_awburst_i = 2'b01;
  logic        axi_wvalid_i = 1'b0;
  logic        axi_wready_o;
  logic [31:0] axi_wdata_i = 32'h0;
  logic [3:0]  axi_wstrb_i = 4'h0;
  logic        axi_wlast_i = 1'b0;
  logic        axi_bvalid_o;
  logic        axi_bready_i = 1'b0;
  logic [1:0]  axi_bresp_o;
  logic [3:0]  axi_bid_o;
  logic        axi_arvalid_i = 1'b0;
  logic        axi_arready_o;
  logic [31:0] axi_araddr_i = 32'h0;
  logic [3:0]  axi_arid_i = 4'h0;
  logic [7:0]  axi_arlen_i = 8'h0;
  logic [1:0]  axi_arburst_i = 2'b01;
  logic        axi_rvalid_o;
  logic        axi_rready_i = 1'b0;
  logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic [3:0]  axi_rid_o;
  logic        axi_rlast_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  axi4_mem_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
    .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
    .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
    .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
    .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
    .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
    .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
    .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic aw_hs(input logic [31:0] a, input logic [3:0] id,
                       input logic [7:0] len, input logic [1:0] b);
    int n = 0;
    axi_awvalid_i = 1'b1; axi_awaddr_i = a; axi_awid_i = id;
    axi_awlen_i = len; axi_awburst_i = b;
    #1;
    while (!axi_awready_o && n < 20) begin step(); n++; end
    chk("aw_accept", axi_awready_o, 1);
    step();
    axi_awvalid_i = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] a, input logic [3:0] id,
                       input logic [7:0] len, input logic [1:0] b);
    int n = 0;
    axi_arvalid_i = 1'b1; axi_araddr_i = a; axi_arid_i = id;
    axi_arlen_i = len; axi_arburst_i = b;
    #1;
    while (!axi_arready_o && n < 20) begin step(); n++; end
    chk("ar_accept", axi_arready_o, 1);
    step();
    axi_arvalid_i = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi_wvalid_i = 1'b1; axi_wdata_i = d; axi_wstrb_i = s;
    #1;
    while (!axi_wready_o && n < 20) begin step(); n++; end
    chk("wready", axi_wready_o, 1);
    step();
    axi_wvalid_i = 1'b0;
  endtask

  // Called right after the final W handshake: bvalid must already be up.
  task automatic b_resp(input logic [1:0] resp, input logic [3:0] id);
    chk("bvalid", axi_bvalid_o, 1);
    chk("bresp", axi_bresp_o, resp);
    chk("bid", axi_bid_o, id);
    axi_bready_i = 1'b1;
    step();
    axi_bready_i = 1'b0;
    chk("bvalid_drop", axi_bvalid_o, 0);
  endtask

  task automatic r_expect(input logic [31:0] d, input logic [1:0] resp,
                          input logic last, input logic [3:0] id);
    chk("rvalid", axi_rvalid_o, 1);
    chk("rdata", axi_rdata_o, d);
    chk("rresp", axi_rresp_o, resp);
    chk("rlast", axi_rlast_o, last);
    chk("rid", axi_rid_o, id);
    chk("arready_busy", axi_arready_o, 0);
    axi_rready_i = 1'b1;
    step();
  endtask

  initial begin
    // Reset: readies and all registered outputs low even with valids up.
    #1;
    rst_i = 1'b1; axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
    #2;
    chk("rst_awready", axi_awready_o, 0);
    chk("rst_arready", axi_arready_o, 0);
    chk("rst_bvalid", axi_bvalid_o, 0);
    chk("rst_rvalid", axi_rvalid_o, 0);
    chk("rst_rdata", axi_rdata_o, 0);
    chk("rst_wready", axi_wready_o, 0);
    step(); step();
    axi_awvalid_i = 1'b0; axi_arvalid_i = 1'b0;
    rst_i = 1'b0;
    step();

    // First tie after reset: read wins.
    axi_awvalid_i = 1'b1; axi_awaddr_i = 32'h8000_0010; axi_awid_i = 4'd3;
    axi_awlen_i = 8'd0; axi_awburst_i = 2'b01;
    axi_arvalid_i = 1'b1; axi_araddr_i = 32'h8000_0040; axi_arid_i = 4'd5;
    axi_arlen_i = 8'd0; axi_arburst_i = 2'b01;
    #1;
    chk("tie1_arready", axi_arready_o, 1);
    chk("tie1_awready", axi_awready_o, 0);
    step();
    axi_arvalid_i = 1'b0;
    #1;
    chk("tie1_aw_blocked", axi_awready_o, 0);
    // rready backpressure for 3 cycles: beat held stable.
    for (int i = 0; i < 3; i++) begin
      chk("rbp_rvalid", axi_rvalid_o, 1);
      chk("rbp_rid", axi_rid_o, 5);
      chk("rbp_rlast", axi_rlast_o, 1);
      chk("rbp_rresp", axi_rresp_o, 0);
      step();
    end
    axi_rready_i = 1'b1;
    step();
    axi_rready_i = 1'b0;
    // Second tie: write wins.
    axi_arvalid_i = 1'b1;
    #1;
    chk("tie2_awready", axi_awready_o, 1);
    chk("tie2_arready", axi_arready_o, 0);
    step();
    axi_awvalid_i = 1'b0; axi_arvalid_i = 1'b0;
    w_beat(32'hDEAD_BEEF, 4'hF);
    // bready backpressure for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      chk("bbp_bvalid", axi_bvalid_o, 1);
      chk("bbp_bid", axi_bid_o, 3);
      step();
    end
    b_resp(2'b00, 4'd3);

    // Read back single word.
    ar_hs(32'h8000_0010, 4'd9, 8'd0, 2'b01);
    r_expect(32'hDEAD_BEEF, 2'b00, 1'b1, 4'd9);
    axi_rready_i = 1'b0;
    chk("rvalid_idle", axi_rvalid_o, 0);

    // Preload words 0..7 with an INCR write burst.
    aw_hs(32'h8000_0000, 4'd1, 8'd7, 2'b01);
    for (int k = 0; k < 8; k++) w_beat(32'(k), 4'hF);
    b_resp(2'b00, 4'd1);

    // INCR read len 7; a WRAP AR waits and must be taken right after the last beat.
    ar_hs(32'h8000_0000, 4'd1, 8'd7, 2'b01);
    axi_arvalid_i = 1'b1; axi_araddr_i = 32'h8000_0018; axi_arid_i = 4'd2;
    axi_arlen_i = 8'd3; axi_arburst_i = 2'b10;
    #1;
    for (int k = 0; k < 8; k++) r_expect(32'(k), 2'b00, k == 7, 4'd1);
    chk("turnaround_ar", axi_arready_o, 1);
    step();
    axi_arvalid_i = 1'b0;
    r_expect(32'd6, 2'b00, 1'b0, 4'd2);
    r_expect(32'd7, 2'b00, 1'b0, 4'd2);
    r_expect(32'd4, 2'b00, 1'b0, 4'd2);
    r_expect(32'd5, 2'b00, 1'b1, 4'd2);
    axi_rready_i = 1'b0;

    // Strobe write: only bytes 0 and 2 take the new data.
    aw_hs(32'h8000_0020, 4'd3, 8'd0, 2'b01);
    w_beat(32'hAABB_CCDD, 4'hF);
    b_resp(2'b00, 4'd3);
    aw_hs(32'h8000_0020, 4'd3, 8'd0, 2'b01);
    w_beat(32'h1122_3344, 4'b0101);
    b_resp(2'b00, 4'd3);
    ar_hs(32'h8000_0020, 4'd4, 8'd0, 2'b01);
    r_expect(32'hAA22_CC44, 2'b00, 1'b1, 4'd4);
    axi_rready_i = 1'b0;

    // FIXED bursts keep hitting one word.
    aw_hs(32'h8000_0024, 4'd5, 8'd2, 2'b00);
    w_beat(32'd1, 4'hF); w_beat(32'd2, 4'hF); w_beat(32'd3, 4'hF);
    b_resp(2'b00, 4'd5);
    ar_hs(32'h8000_0024, 4'd6, 8'd1, 2'b00);
    r_expect(32'd3, 2'b00, 1'b0, 4'd6);
    r_expect(32'd3, 2'b00, 1'b1, 4'd6);
    axi_rready_i = 1'b0;

    // Out of range: 0x7FFFFFFC aliases the last word if the range test is missing.
    aw_hs(32'h8000_FFFC, 4'd7, 8'd0, 2'b01);
    w_beat(32'hCAFE_F00D, 4'hF);
    b_resp(2'b00, 4'd7);
    aw_hs(32'h7FFF_FFFC, 4'd7, 8'd0, 2'b01);
    w_beat(32'h1234_5678, 4'hF);
    b_resp(2'b11, 4'd7);
    ar_hs(32'h8000_FFFC, 4'd8, 8'd1, 2'b01);
    r_expect(32'hCAFE_F00D, 2'b00, 1'b0, 4'd8);
    r_expect(32'h0, 2'b11, 1'b1, 4'd8);
    axi_rready_i = 1'b0;

    // Reset during beat 3 of a len-7 read.
    ar_hs(32'h8000_0000, 4'd4, 8'd7, 2'b01);
    for (int k = 0; k < 3; k++) r_expect(32'(k), 2'b00, 1'b0, 4'd4);
    chk("beat3_data", axi_rdata_o, 3);
    axi_arvalid_i = 1'b1; axi_araddr_i = 32'h8000_0008; axi_arid_i = 4'd6;
    axi_arlen_i = 8'd0; axi_arburst_i = 2'b01;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_rvalid", axi_rvalid_o, 0);
    chk("mid_rst_rdata", axi_rdata_o, 0);
    chk("mid_rst_rid", axi_rid_o, 0);
    chk("mid_rst_rlast", axi_rlast_o, 0);
    chk("mid_rst_rresp", axi_rresp_o, 0);
    chk("mid_rst_arready", axi_arready_o, 0);
    step();
    rst_i = 1'b0;
    #1;
    chk("post_rst_arready", axi_arready_o, 1);
    step();
    axi_arvalid_i = 1'b0;
    r_expect(32'd2, 2'b00, 1'b1, 4'd6);
    axi_rready_i = 1'b0;
    chk("post_rst_idle", axi_rvalid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
